pe_alu_pipe: RTL

Pipelined, parametrised processing-element ALU. It wraps the full primitive operation set (add, sub, mult, shifts, select, logic, compare) behind a 2-stage valid/ready pipeline. It adds a chained-carry mode for multi-word arithmetic and sticky illegal-opcode detection. It sits between the PE operand routers and the PE output register file, and replaces per-operation primitive instantiation in the PE datapath.

---
 rtl/pe_alu_pkg.sv | 33 +++
 rtl/pe_alu_pipe_if.sv | 30 +++
 rtl/pe_alu_core.sv | 61 ++++++
 rtl/pe_alu_pipe.sv | 105 ++++++++++
 4 files changed

// File: rtl/pe_alu_pkg.sv
// rtl/pe_alu_pkg.sv - opcode, width and result types shared by the PE ALU pipeline
package pe_alu_pkg;

  localparam int OP_W       = 4;
  localparam int CARRY_W    = 1;
  localparam int WORD_W_DEF = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MULT    = 4'd2,
    OP_SL      = 4'd3,
    OP_SR      = 4'd4,
    OP_SRA     = 4'd5,
    OP_SEL     = 4'd6,
    OP_CAT     = 4'd7,
    OP_NOT     = 4'd8,
    OP_AND     = 4'd9,
    OP_OR      = 4'd10,
    OP_XOR     = 4'd11,
    OP_EQL     = 4'd12,
    OP_GT      = 4'd13,
    OP_LT      = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  // Result layout {carry, word}; the parametrised datapath keeps the same bit order.
  typedef struct packed {
    logic [CARRY_W-1:0]    carry;
    logic [WORD_W_DEF-1:0] word;
  } result_t;

endpackage

// File: rtl/pe_alu_pipe_if.sv
// rtl/pe_alu_pipe_if.sv - operand/op bundle in, result out, plus error flag controls
interface pe_alu_pipe_if #(parameter int WORD_W = 16);
  import pe_alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic              in_c_a;
  logic              in_c_b;
  logic              in_chain;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out;
  logic              out_c;
  logic              err;
  logic              clr_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_c_a, in_c_b, in_chain, out_ready, clr_err,
    input  in_ready, out_valid, out, out_c, err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_c_a, in_c_b, in_chain, out_ready, clr_err,
    output in_ready, out_valid, out, out_c, err
  );

endinterface

// File: rtl/pe_alu_core.sv
// rtl/pe_alu_core.sv - combinational PE operation mux on {carry, word} operands
module pe_alu_core
  import pe_alu_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  op_e               op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ca,
  input  logic              cb,
  output logic [WORD_W-1:0] res_word,
  output logic              res_c,
  output logic              illegal
);

  localparam int SHAMT_W = $clog2(WORD_W + 2);
  localparam int EXT_W   = WORD_W + 1;
  localparam logic [WORD_W-1:0] SH_LIMIT = WORD_W'(EXT_W);

  logic [EXT_W-1:0]   ea;
  logic [EXT_W-1:0]   eb;
  logic [EXT_W-1:0]   ext;
  logic [WORD_W-1:0]  prod;
  logic [SHAMT_W-1:0] shamt;
  logic               sh_big;

  assign ea    = {ca, a};
  assign eb    = {cb, b};
  assign prod  = a * b;
  // Shifts of the full extended word saturate once every bit has moved out.
  assign sh_big = (b >= SH_LIMIT);
  assign shamt  = b[SHAMT_W-1:0];

  always_comb begin
    ext     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  ext = ea + eb;
      OP_SUB:  ext = ea + ~eb + EXT_W'(1);
      OP_MULT: ext = {ca ^ cb, prod};
      OP_SL:   ext = sh_big ? '0 : (ea << shamt);
      OP_SR:   ext = sh_big ? '0 : (ea >> shamt);
      OP_SRA:  ext = sh_big ? {EXT_W{ca}} : $unsigned($signed(ea) >>> shamt);
      OP_SEL:  ext = ca ? eb : ea;
      OP_CAT:  ext = ea;
      OP_NOT:  ext = ~ea;
      OP_AND:  ext = ea & eb;
      OP_OR:   ext = ea | eb;
      OP_XOR:  ext = {|(a ^ b), a ^ b};
      OP_EQL:  ext = (a == b) ? {1'b1, a} : '0;
      OP_GT:   ext = (ca ? (a >= b) : (a > b)) ? {1'b1, a} : {1'b0, b};
      OP_LT:   ext = (ca ? (a <= b) : (a < b)) ? {1'b1, a} : {1'b0, b};
      default: illegal = 1'b1;
    endcase
  end

  assign res_c    = ext[WORD_W];
  assign res_word = ext[WORD_W-1:0];

endmodule

// File: rtl/pe_alu_pipe.sv
// rtl/pe_alu_pipe.sv - two-stage valid/ready PE ALU with chained carry and sticky illegal-op flag
module pe_alu_pipe
  import pe_alu_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input logic          clk,
  input logic          rst_x,
  pe_alu_pipe_if.slave bus
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [WORD_W-1:0] s1_a;
  logic [WORD_W-1:0] s1_b;
  logic              s1_c_a;
  logic              s1_c_b;
  logic              s1_chain;

  logic              s2_valid;
  logic [WORD_W-1:0] s2_word;
  logic              s2_c;
  logic              chain_c;
  logic              err_q;

  logic              s2_load;
  logic              in_ready;
  logic              in_fire;
  logic              eff_ca;
  logic [WORD_W-1:0] core_word;
  logic              core_c;
  logic              core_illegal;

  assign s2_load  = s1_valid & (~s2_valid | bus.out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = bus.in_valid & in_ready;
  // Chain carry is read at the stage-2 edge, so a stalled predecessor has already updated it.
  assign eff_ca   = s1_chain ? chain_c : s1_c_a;

  pe_alu_core #(.WORD_W(WORD_W)) u_core (
    .op       (op_e'(s1_op)),
    .a        (s1_a),
    .b        (s1_b),
    .ca       (eff_ca),
    .cb       (s1_c_b),
    .res_word (core_word),
    .res_c    (core_c),
    .illegal  (core_illegal)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c_a   <= 1'b0;
      s1_c_b   <= 1'b0;
      s1_chain <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.in_op;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_c_a   <= bus.in_c_a;
      s1_c_b   <= bus.in_c_b;
      s1_chain <= bus.in_chain;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_c     <= 1'b0;
      chain_c  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_word  <= core_word;
      s2_c     <= core_c;
      chain_c  <= core_c;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      err_q <= 1'b0;
    end else if (s2_load && core_illegal) begin
      err_q <= 1'b1;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_word;
  assign bus.out_c     = s2_c;
  assign bus.err       = err_q;

endmodule
